dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-port 8-bit data memory (256 x 8, synchronous write, combinational read). It sits between the memory and its two masters: requester 0 (core load/store unit) and requester 1 (DMA/loader). It grants at most one access per cycle using round-robin priority, optionally locks the memory to one requester for atomic sequences, and returns read data through a registered response with one-cycle latency.

## Interface
- LOCK_MAX, default 8: maximum consecutive cycles a lock may be held without an accepted beat from the owner before it is forcibly released; minimum 1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  (N = 0, 1) requester N has a pending access.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  8  byte address.
- reqN_wdata  in  8  write data.
- reqN_lock  in  1  acquire or keep the lock with this beat.
- reqN_ready  out  1  the access is accepted this cycle when valid && ready.
- rspN_valid  out  1  one-cycle pulse: read data is valid.
- rspN_rdata  out  8  read data; holds its last value between pulses.
- lock_abort  out  1  one-cycle pulse: lock forcibly released by timeout.
- mem_addr  out  8  to memory DataAddress.
- mem_read  out  1  to memory ReadMem.
- mem_write  out  1  to memory WriteMem.
- mem_wdata  out  8  to memory DataIn.
- mem_rdata  in  8  from memory DataOut (combinational).

## Operation
- States: UNLOCKED, LOCKED0, LOCKED1. A 1-bit priority pointer prio is 0 after reset.
- UNLOCKED grant: if exactly one requester is valid, it is granted; if both are valid, requester prio is granted. After any accepted beat, prio becomes the other requester.
- LOCKEDk grant: only requester k may be granted, and the other requester's ready is 0. prio still updates on each accepted beat.
- reqN_ready is combinational: it is 1 only for the requester granted this cycle, and never high for both requesters.
- Memory port, driven combinationally from the granted requester:
  - mem_addr = addr.
  - mem_write = we.
  - mem_read = !we.
  - mem_wdata = wdata.
  - With no grant, every memory output is 0.
- Lock transitions:
  - UNLOCKED to LOCKEDk on an accepted beat from k with lock = 1.
  - LOCKEDk to UNLOCKED on an accepted beat from k with lock = 0. That beat is itself performed.
  - A beat with lock = 1 while already LOCKEDk keeps the lock.
- Lock timeout:
  - An idle counter (width clog2(LOCK_MAX+1)) clears on entry to LOCKEDk and on every accepted owner beat, and increments on every other locked cycle.
  - When it reaches LOCK_MAX, the next state is UNLOCKED, lock_abort pulses for 1 cycle (the cycle after), and the counter clears.
  - An owner beat in that same cycle wins: it is accepted, the counter clears, and there is no abort.
- Responses:
  - On an accepted read, mem_rdata is captured into rspN_rdata at that rising edge, and rspN_valid is 1 in the following cycle only.
  - Writes produce no response.
  - Back-to-back reads from the same requester give back-to-back rsp pulses.
- Hazards: accesses are serialised, so a read accepted in the cycle after a write to the same address returns the new data.

## Timing
- Throughput: one access per cycle.
- Read latency: 1 cycle from acceptance to rsp_valid.
- Write commits at the rising edge ending the acceptance cycle.
- Reset (asynchronous, any time including mid-lock or with a response pending):
  - State is UNLOCKED, prio = 0, counter = 0.
  - rsp0_valid, rsp1_valid and lock_abort are 0.
  - rsp0_rdata and rsp1_rdata are 0x00.
  - The memory outputs and readies follow from the inputs (all 0 while no valid is asserted).
  - A response pending at reset is dropped.
- Memory contents are not reset by this block.

## Test plan
- Single read: preload mem[0x05] = 0xA7; req0 read 0x05 -> req0_ready = 1 the same cycle, rsp0_valid = 1 the next cycle with rdata 0xA7, rsp1_valid stays 0.
- Contention: both requesters valid continuously, reading 0x10 and 0x20 -> grants alternate 0, 1, 0, 1 starting with 0 after reset; never both ready; each response appears on its own requester's port.
- Write-then-read across requesters: req1 writes 0x3C to 0x40 in cycle t, req0 reads 0x40 in cycle t+1 -> rsp0_rdata = 0x3C at t+2.
- Lock: req0 lock beat (write 0x11 to 0x01) while req1 is valid throughout -> req1_ready = 0 until req0 sends a beat with lock = 0; req1 is granted the cycle after that release beat; no lock_abort.
- Timeout, LOCK_MAX = 4: req1 locks and then goes idle, req0 valid -> lock_abort pulses exactly once; req0 is first granted at the 5th cycle after the lock beat (counter reaches 4 at the end of the 4th idle locked cycle, so the 5th cycle is UNLOCKED); an owner beat landing in the 4th idle cycle suppresses the abort.
- Reset mid-operation: assert rst_n = 0 in the cycle after a read acceptance, while LOCKED0 -> rsp0_valid = 0 immediately; after release, both requesters valid -> requester 0 is granted first and the state is UNLOCKED.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, response and memory-port signal bundle for dmem_arbiter
interface dmem_arbiter_if;
  logic       req0_valid;
  logic       req0_we;
  logic [7:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req0_lock;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_we;
  logic [7:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       req1_lock;
  logic       req1_ready;
  logic       rsp0_valid;
  logic [7:0] rsp0_rdata;
  logic       rsp1_valid;
  logic [7:0] rsp1_rdata;
  logic       lock_abort;
  logic [7:0] mem_addr;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata, req0_lock,
    input  req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata, lock_abort,
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, req0_lock,
    output req1_valid, req1_we, req1_addr, req1_wdata, req1_lock,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata, lock_abort,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-requester data memory arbiter with lock and timeout
module dmem_arbiter #(
  parameter int LOCK_MAX = 8
) (
  input logic            clk,
  input logic            rst_n,
  dmem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_t;

  state_t        state_q, state_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_q, abort_d;
  logic          gnt0, gnt1;
  logic          own_gnt, own_lock;
  logic          rsp0_valid_q, rsp1_valid_q;
  logic [7:0]    rsp0_rdata_q, rsp1_rdata_q;

  // Grant: round-robin when unlocked, owner-only when locked
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      UNLOCKED: begin
        gnt0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
        gnt1 = bus.req1_valid && (!bus.req0_valid || prio_q);
      end
      LOCKED0: gnt0 = bus.req0_valid;
      LOCKED1: gnt1 = bus.req1_valid;
      default: ;
    endcase
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Memory port mux: granted requester drives the memory, all zero when idle
  always_comb begin
    bus.mem_addr  = 8'h00;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_wdata = 8'h00;
    if (gnt0) begin
      bus.mem_addr  = bus.req0_addr;
      bus.mem_read  = !bus.req0_we;
      bus.mem_write = bus.req0_we;
      bus.mem_wdata = bus.req0_wdata;
    end else if (gnt1) begin
      bus.mem_addr  = bus.req1_addr;
      bus.mem_read  = !bus.req1_we;
      bus.mem_write = bus.req1_we;
      bus.mem_wdata = bus.req1_wdata;
    end
  end

  // Lock owner view: whether the current owner was granted and still wants the lock
  always_comb begin
    own_gnt  = 1'b0;
    own_lock = 1'b0;
    if (state_q == LOCKED0) begin
      own_gnt  = gnt0;
      own_lock = bus.req0_lock;
    end else if (state_q == LOCKED1) begin
      own_gnt  = gnt1;
      own_lock = bus.req1_lock;
    end
  end

  // Next state: lock acquire/release, idle timeout, round-robin pointer
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    if (gnt0 || gnt1) begin
      prio_d = gnt0;
    end
    if (state_q == UNLOCKED) begin
      cnt_d = '0;
      if (gnt0 && bus.req0_lock) begin
        state_d = LOCKED0;
      end else if (gnt1 && bus.req1_lock) begin
        state_d = LOCKED1;
      end
    end else if (own_gnt) begin
      // An owner beat always wins over a timeout in the same cycle
      cnt_d = '0;
      if (!own_lock) begin
        state_d = UNLOCKED;
      end
    end else if (cnt_q == CNT_LAST) begin
      state_d = UNLOCKED;
      cnt_d   = '0;
      abort_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      prio_q  <= 1'b0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  // Read responses: capture memory data at acceptance, pulse valid next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= 8'h00;
      rsp1_rdata_q <= 8'h00;
    end else begin
      rsp0_valid_q <= gnt0 && !bus.req0_we;
      rsp1_valid_q <= gnt1 && !bus.req1_we;
      if (gnt0 && !bus.req0_we) begin
        rsp0_rdata_q <= bus.mem_rdata;
      end
      if (gnt1 && !bus.req1_we) begin
        rsp1_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;
  assign bus.lock_abort = abort_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.LOCK_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Memory model: synchronous write, combinational read, plus a preload path
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d, input logic lk);
    bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_lock = lk;
  endtask

  task automatic set1(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d, input logic lk);
    bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_lock = lk;
  endtask

  initial begin
    rst_n  = 1'b0;
    pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
    set0(0, 0, 8'h00, 8'h00, 0);
    set1(0, 0, 8'h00, 8'h00, 0);

    // Preload memory while held in reset
    pre_we = 1'b1; pre_addr = 8'h05; pre_data = 8'hA7; tick();
    pre_addr = 8'h10; pre_data = 8'h5A; tick();
    pre_addr = 8'h20; pre_data = 8'hC3; tick();
    pre_we = 1'b0;

    // Reset state
    #1;
    chk("rst_rdy0", bus.req0_ready, 0);
    chk("rst_rdy1", bus.req1_ready, 0);
    chk("rst_rsp0v", bus.rsp0_valid, 0);
    chk("rst_rsp1v", bus.rsp1_valid, 0);
    chk("rst_rsp0d", bus.rsp0_rdata, 8'h00);
    chk("rst_rsp1d", bus.rsp1_rdata, 8'h00);
    chk("rst_abort", bus.lock_abort, 0);
    chk("rst_mrd", bus.mem_read, 0);
    chk("rst_mwr", bus.mem_write, 0);
    chk("rst_maddr", bus.mem_addr, 8'h00);
    rst_n = 1'b1;
    tick();

    // Single read
    set0(1, 0, 8'h05, 8'h00, 0); #1;
    chk("rd_rdy0", bus.req0_ready, 1);
    chk("rd_rdy1", bus.req1_ready, 0);
    chk("rd_mrd", bus.mem_read, 1);
    chk("rd_mwr", bus.mem_write, 0);
    chk("rd_maddr", bus.mem_addr, 8'h05);
    tick();
    set0(0, 0, 8'h00, 8'h00, 0); #1;
    chk("rd_rsp0v", bus.rsp0_valid, 1);
    chk("rd_rsp0d", bus.rsp0_rdata, 8'hA7);
    chk("rd_rsp1v", bus.rsp1_valid, 0);
    chk("rd_maddr_idle", bus.mem_addr, 8'h00);
    tick(); #1;
    chk("rd_rsp0v_pulse", bus.rsp0_valid, 0);
    chk("rd_rsp0d_hold", bus.rsp0_rdata, 8'hA7);

    // Contention after a fresh reset: grants alternate starting with 0
    rst_n = 1'b0; #1; rst_n = 1'b1;
    tick();
    set0(1, 0, 8'h10, 8'h00, 0);
    set1(1, 0, 8'h20, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("ct_rdy0_%0d", i), bus.req0_ready, (i % 2 == 0));
      chk($sformatf("ct_rdy1_%0d", i), bus.req1_ready, (i % 2 == 1));
      chk($sformatf("ct_maddr_%0d", i), bus.mem_addr, (i % 2 == 0) ? 8'h10 : 8'h20);
      if (i > 0) begin
        chk($sformatf("ct_rsp0v_%0d", i), bus.rsp0_valid, ((i - 1) % 2 == 0));
        chk($sformatf("ct_rsp1v_%0d", i), bus.rsp1_valid, ((i - 1) % 2 == 1));
      end
      tick();
    end
    set0(0, 0, 8'h00, 8'h00, 0);
    set1(0, 0, 8'h00, 8'h00, 0); #1;
    chk("ct_rsp1v_last", bus.rsp1_valid, 1);
    chk("ct_rsp1d", bus.rsp1_rdata, 8'hC3);
    chk("ct_rsp0d", bus.rsp0_rdata, 8'h5A);
    chk("ct_rsp0v_last", bus.rsp0_valid, 0);
    tick();

    // Write by req1, then read of the same address by req0
    set1(1, 1, 8'h40, 8'h3C, 0); #1;
    chk("wr_rdy1", bus.req1_ready, 1);
    chk("wr_mwr", bus.mem_write, 1);
    chk("wr_mrd", bus.mem_read, 0);
    chk("wr_mwdata", bus.mem_wdata, 8'h3C);
    chk("wr_maddr", bus.mem_addr, 8'h40);
    tick();
    set1(0, 0, 8'h00, 8'h00, 0);
    set0(1, 0, 8'h40, 8'h00, 0); #1;
    chk("wtr_rdy0", bus.req0_ready, 1);
    chk("wtr_no_wr_rsp", bus.rsp1_valid, 0);
    tick();
    set0(0, 0, 8'h00, 8'h00, 0); #1;
    chk("wtr_rsp0v", bus.rsp0_valid, 1);
    chk("wtr_rsp0d", bus.rsp0_rdata, 8'h3C);
    tick();

    // Lock by req0 while req1 stays valid
    set1(1, 0, 8'h20, 8'h00, 0); #1;
    chk("lk_pre_rdy1", bus.req1_ready, 1);
    tick();
    set0(1, 1, 8'h01, 8'h11, 1); #1;
    chk("lk_acq_rdy0", bus.req0_ready, 1);
    chk("lk_acq_rdy1", bus.req1_ready, 0);
    tick();
    set0(1, 0, 8'h01, 8'h00, 1); #1;
    chk("lk_hold_rdy0", bus.req0_ready, 1);
    chk("lk_hold_rdy1", bus.req1_ready, 0);
    tick();
    set0(0, 0, 8'h00, 8'h00, 0); #1;
    chk("lk_idle_rdy1", bus.req1_ready, 0);
    chk("lk_rsp0v", bus.rsp0_valid, 1);
    chk("lk_rsp0d", bus.rsp0_rdata, 8'h11);
    tick();
    set0(1, 0, 8'h01, 8'h00, 0); #1;
    chk("lk_rel_rdy0", bus.req0_ready, 1);
    chk("lk_rel_rdy1", bus.req1_ready, 0);
    tick();
    set0(0, 0, 8'h00, 8'h00, 0); #1;
    chk("lk_after_rdy1", bus.req1_ready, 1);
    chk("lk_after_abort", bus.lock_abort, 0);
    tick();
    set1(0, 0, 8'h00, 8'h00, 0); #1;
    chk("lk_end_rsp1v", bus.rsp1_valid, 1);
    chk("lk_end_abort", bus.lock_abort, 0);

    // Timeout: req1 locks and goes idle, req0 waits
    set1(1, 0, 8'h20, 8'h00, 1); #1;
    chk("to_lock_rdy1", bus.req1_ready, 1);
    tick();
    set1(0, 0, 8'h00, 8'h00, 0);
    set0(1, 0, 8'h05, 8'h00, 0);
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("to_wait_rdy0_%0d", i), bus.req0_ready, 0);
      chk($sformatf("to_wait_abort_%0d", i), bus.lock_abort, 0);
      tick();
    end
    #1;
    chk("to_rdy0", bus.req0_ready, 1);
    chk("to_abort", bus.lock_abort, 1);
    tick(); #1;
    chk("to_abort_once", bus.lock_abort, 0);
    chk("to_rsp0v", bus.rsp0_valid, 1);
    chk("to_rdy0_again", bus.req0_ready, 1);
    tick();
    set0(0, 0, 8'h00, 8'h00, 0);

    // Owner beat in the 4th idle cycle suppresses the timeout
    set1(1, 0, 8'h20, 8'h00, 1); #1;
    chk("sp_lock_rdy1", bus.req1_ready, 1);
    tick();
    set1(0, 0, 8'h00, 8'h00, 0);
    set0(1, 0, 8'h05, 8'h00, 0);
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("sp_wait_rdy0_%0d", i), bus.req0_ready, 0);
      tick();
    end
    set1(1, 0, 8'h20, 8'h00, 1); #1;
    chk("sp_beat_rdy1", bus.req1_ready, 1);
    chk("sp_beat_rdy0", bus.req0_ready, 0);
    tick();
    set1(0, 0, 8'h00, 8'h00, 0);
    for (int i = 5; i <= 8; i++) begin
      #1;
      chk($sformatf("sp_abort_%0d", i), bus.lock_abort, 0);
      chk($sformatf("sp_rdy0_%0d", i), bus.req0_ready, 0);
      tick();
    end
    #1;
    chk("sp_late_abort", bus.lock_abort, 1);
    chk("sp_late_rdy0", bus.req0_ready, 1);
    tick();
    set0(0, 0, 8'h00, 8'h00, 0);

    // Reset while LOCKED0 with a response pending
    set0(1, 0, 8'h05, 8'h00, 1); #1;
    chk("mr_rdy0", bus.req0_ready, 1);
    tick();
    set0(0, 0, 8'h00, 8'h00, 0); #1;
    chk("mr_pending", bus.rsp0_valid, 1);
    rst_n = 1'b0; #1;
    chk("mr_rsp0v", bus.rsp0_valid, 0);
    chk("mr_rsp0d", bus.rsp0_rdata, 8'h00);
    chk("mr_abort", bus.lock_abort, 0);
    tick();
    rst_n = 1'b1;
    set0(1, 0, 8'h05, 8'h00, 0);
    set1(1, 0, 8'h20, 8'h00, 0); #1;
    chk("mr_first_rdy0", bus.req0_ready, 1);
    chk("mr_first_rdy1", bus.req1_ready, 0);
    tick(); #1;
    chk("mr_second_rdy1", bus.req1_ready, 1);
    chk("mr_second_rdy0", bus.req0_ready, 0);
    tick();
    set0(0, 0, 8'h00, 8'h00, 0);
    set1(0, 0, 8'h00, 8'h00, 0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
